// File: rtl/serpent_encrypt_round_seq.sv
// Iterative Serpent encryption round sequencer.
// One plaintext block is folded through the external combinational round
// stage once per cycle. Each round's input is the current state XORed with
// that round's subkey, and the stage output becomes the new state. After the
// 32nd round the K32 subkey is mixed in and the ciphertext is held until the
// downstream side acknowledges it. A low i_subkey_valid freezes progress for
// as long as the key schedule needs.
module serpent_encrypt_round_seq #(
    parameter int WORD_W   = 32,
    parameter int N_ROUNDS = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WORD_W-1:0] i_pt_word_0,
    input  logic [WORD_W-1:0] i_pt_word_1,
    input  logic [WORD_W-1:0] i_pt_word_2,
    input  logic [WORD_W-1:0] i_pt_word_3,
    output logic [5:0]        o_subkey_idx,
    input  logic [WORD_W-1:0] i_subkey_word_0,
    input  logic [WORD_W-1:0] i_subkey_word_1,
    input  logic [WORD_W-1:0] i_subkey_word_2,
    input  logic [WORD_W-1:0] i_subkey_word_3,
    input  logic              i_subkey_valid,
    output logic [WORD_W-1:0] o_stage_word_0,
    output logic [WORD_W-1:0] o_stage_word_1,
    output logic [WORD_W-1:0] o_stage_word_2,
    output logic [WORD_W-1:0] o_stage_word_3,
    output logic [5:0]        o_stage_round,
    input  logic [WORD_W-1:0] i_stage_word_0,
    input  logic [WORD_W-1:0] i_stage_word_1,
    input  logic [WORD_W-1:0] i_stage_word_2,
    input  logic [WORD_W-1:0] i_stage_word_3,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_ct_word_0,
    output logic [WORD_W-1:0] o_ct_word_1,
    output logic [WORD_W-1:0] o_ct_word_2,
    output logic [WORD_W-1:0] o_ct_word_3,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    typedef logic [3:0][WORD_W-1:0] block_t;

    localparam logic [5:0] LAST_ROUND = 6'(N_ROUNDS);
    localparam logic [5:0] FINAL_IDX  = 6'(N_ROUNDS);
    localparam block_t     ZERO_BLOCK = '0;

    // Key mixing is a plain bitwise XOR of all four words, no carries.
    function automatic block_t xor_block(input block_t a, input block_t b);
        return a ^ b;
    endfunction

    fsm_t   fsm_r;
    fsm_t   fsm_nx_s;
    block_t state_r;
    block_t state_nx_s;
    block_t ct_r;
    block_t ct_nx_s;
    logic [5:0] round_r;
    logic [5:0] round_nx_s;
    logic       valid_r;
    logic       valid_nx_s;

    block_t pt_s;
    block_t subkey_s;
    block_t stage_res_s;
    block_t mix_s;
    block_t stage_out_s;
    logic [5:0] subkey_idx_s;
    logic [5:0] stage_round_s;

    assign pt_s        = {i_pt_word_3, i_pt_word_2, i_pt_word_1, i_pt_word_0};
    assign subkey_s    = {i_subkey_word_3, i_subkey_word_2, i_subkey_word_1, i_subkey_word_0};
    assign stage_res_s = {i_stage_word_3, i_stage_word_2, i_stage_word_1, i_stage_word_0};

    // The same mix feeds the stage in ROUND and forms the ciphertext in FINAL.
    assign mix_s = xor_block(state_r, subkey_s);

    // Next-state logic: sequencing, stalls on subkey availability, DONE handshake.
    always_comb begin
        fsm_nx_s   = fsm_r;
        state_nx_s = state_r;
        round_nx_s = round_r;
        ct_nx_s    = ct_r;
        valid_nx_s = valid_r;
        case (fsm_r)
            IDLE: begin
                if (i_valid) begin
                    state_nx_s = pt_s;
                    round_nx_s = 6'd1;
                    fsm_nx_s   = ROUND;
                end else begin
                    fsm_nx_s   = IDLE;
                end
            end
            ROUND: begin
                if (i_subkey_valid) begin
                    state_nx_s = stage_res_s;
                    if (round_r == LAST_ROUND) begin
                        fsm_nx_s = FINAL;
                    end else begin
                        round_nx_s = round_r + 6'd1;
                    end
                end else begin
                    fsm_nx_s = ROUND;
                end
            end
            FINAL: begin
                if (i_subkey_valid) begin
                    ct_nx_s    = mix_s;
                    valid_nx_s = 1'b1;
                    fsm_nx_s   = DONE;
                end else begin
                    fsm_nx_s   = FINAL;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_nx_s = 1'b0;
                    fsm_nx_s   = IDLE;
                end else begin
                    fsm_nx_s   = DONE;
                end
            end
            default: begin
                fsm_nx_s   = IDLE;
                valid_nx_s = 1'b0;
            end
        endcase
    end

    // Stage and key-store interface: only live during ROUND / FINAL.
    always_comb begin
        subkey_idx_s  = 6'd0;
        stage_round_s = 6'd0;
        stage_out_s   = ZERO_BLOCK;
        case (fsm_r)
            ROUND: begin
                subkey_idx_s  = round_r - 6'd1;
                stage_round_s = round_r;
                stage_out_s   = mix_s;
            end
            FINAL: begin
                subkey_idx_s  = FINAL_IDX;
            end
            default: begin
                subkey_idx_s  = 6'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any block.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fsm_r   <= IDLE;
            state_r <= ZERO_BLOCK;
            round_r <= 6'd0;
            ct_r    <= ZERO_BLOCK;
            valid_r <= 1'b0;
        end else begin
            fsm_r   <= fsm_nx_s;
            state_r <= state_nx_s;
            round_r <= round_nx_s;
            ct_r    <= ct_nx_s;
            valid_r <= valid_nx_s;
        end
    end

    assign o_ready        = (fsm_r == IDLE);
    assign o_busy         = (fsm_r == ROUND) || (fsm_r == FINAL);
    assign o_valid        = valid_r;
    assign o_subkey_idx   = subkey_idx_s;
    assign o_stage_round  = stage_round_s;
    assign o_stage_word_0 = stage_out_s[0];
    assign o_stage_word_1 = stage_out_s[1];
    assign o_stage_word_2 = stage_out_s[2];
    assign o_stage_word_3 = stage_out_s[3];
    assign o_ct_word_0    = ct_r[0];
    assign o_ct_word_1    = ct_r[1];
    assign o_ct_word_2    = ct_r[2];
    assign o_ct_word_3    = ct_r[3];

endmodule

// File: tb/tb_serpent_encrypt_round_seq.sv
// Bench for serpent_encrypt_round_seq: a toy round stage and key store are
// attached, a reference model predicts each ciphertext and its arrival cycle,
// and a monitor pops the scoreboard whenever the sequencer presents output.
module tb_serpent_encrypt_round_seq;

    typedef logic [3:0][31:0] blk_t;
    typedef struct {
        blk_t ct;
        int   due;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  o_subkey_idx;
    logic        i_subkey_valid;
    logic [5:0]  o_stage_round;
    logic        o_valid;
    logic        i_ready;
    logic        o_busy;
    logic [31:0] o_stage_word_0, o_stage_word_1, o_stage_word_2, o_stage_word_3;
    logic [31:0] o_ct_word_0, o_ct_word_1, o_ct_word_2, o_ct_word_3;

    blk_t        pt;
    logic [31:0] key;
    blk_t        sk_v;
    blk_t        stage_in_v;
    blk_t        stage_out_v;
    blk_t        ct_v;
    logic        stall_mode;
    int          stall7;
    int          stallf;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    // Cycle counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ks(input logic [31:0] k, input logic [5:0] idx, input int n);
        return k ^ ({26'd0, idx} * 32'h9E37_79B9) ^ (32'h1111_1111 * 32'(n));
    endfunction

    function automatic blk_t stage_f(input blk_t x, input logic [5:0] r);
        blk_t y;
        for (int n = 0; n < 4; n++)
            y[n] = {x[n][26:0], x[n][31:27]} ^ x[(n + 1) % 4] ^ {26'd0, r};
        return y;
    endfunction

    function automatic blk_t model(input blk_t p, input logic [31:0] k);
        blk_t s;
        blk_t x;
        s = p;
        for (int r = 1; r <= 32; r++) begin
            for (int n = 0; n < 4; n++) x[n] = s[n] ^ ks(k, 6'(r - 1), n);
            s = stage_f(x, 6'(r));
        end
        for (int n = 0; n < 4; n++) s[n] = s[n] ^ ks(k, 6'd32, n);
        return s;
    endfunction

    // Key store and round stage models (combinational, same-cycle).
    always_comb begin
        for (int n = 0; n < 4; n++) sk_v[n] = ks(key, o_subkey_idx, n);
    end
    assign stage_in_v  = {o_stage_word_3, o_stage_word_2, o_stage_word_1, o_stage_word_0};
    assign stage_out_v = stage_f(stage_in_v, o_stage_round);
    assign ct_v        = {o_ct_word_3, o_ct_word_2, o_ct_word_1, o_ct_word_0};

    // Stall injector: 5 cycles at round 7 and 3 cycles in the final mix.
    assign i_subkey_valid = !(stall_mode &&
                              ((o_stage_round == 6'd7 && stall7 > 0) ||
                               (o_subkey_idx == 6'd32 && stallf > 0)));

    // Stall budget bookkeeping; reloads while stall injection is off.
    always @(posedge clk) begin
        if (!stall_mode) begin
            stall7 <= 5;
            stallf <= 3;
        end else if (!i_subkey_valid) begin
            if (o_stage_round == 6'd7) stall7 <= stall7 - 1;
            else stallf <= stallf - 1;
        end
    end

    serpent_encrypt_round_seq dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_pt_word_0    (pt[0]),
        .i_pt_word_1    (pt[1]),
        .i_pt_word_2    (pt[2]),
        .i_pt_word_3    (pt[3]),
        .o_subkey_idx   (o_subkey_idx),
        .i_subkey_word_0(sk_v[0]),
        .i_subkey_word_1(sk_v[1]),
        .i_subkey_word_2(sk_v[2]),
        .i_subkey_word_3(sk_v[3]),
        .i_subkey_valid (i_subkey_valid),
        .o_stage_word_0 (o_stage_word_0),
        .o_stage_word_1 (o_stage_word_1),
        .o_stage_word_2 (o_stage_word_2),
        .o_stage_word_3 (o_stage_word_3),
        .o_stage_round  (o_stage_round),
        .i_stage_word_0 (stage_out_v[0]),
        .i_stage_word_1 (stage_out_v[1]),
        .i_stage_word_2 (stage_out_v[2]),
        .i_stage_word_3 (stage_out_v[3]),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_ct_word_0    (o_ct_word_0),
        .o_ct_word_1    (o_ct_word_1),
        .o_ct_word_2    (o_ct_word_2),
        .o_ct_word_3    (o_ct_word_3),
        .o_busy         (o_busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per presented ciphertext, then checks it stays put.
    task automatic monitor_loop();
        exp_t cur;
        bit   have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (i_rst_n !== 1'b1) begin
                have = 1'b0;
            end else if (o_valid === 1'b1) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 128'd1, 128'd0);
                    end else begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                        chk("latency", 128'(cyc), 128'(cur.due));
                        chk("ct", ct_v, cur.ct);
                    end
                end else begin
                    chk("ct_stable", ct_v, cur.ct);
                end
                chk("ready_in_done", {127'd0, o_ready}, 128'd0);
                if (i_ready) have = 1'b0;
            end
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (o_ready !== 1'b1) chk("ready_timeout", 128'd0, 128'd1);
    endtask

    task automatic send(input blk_t p, input logic [31:0] k, input int stalls,
                        input bit push, input bit keep_valid);
        wait_ready();
        key     = k;
        pt      = p;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = keep_valid;
        chk("accepted_busy", {127'd0, o_busy}, 128'd1);
        if (push) sb.push_back('{ct: model(p, k), due: cyc + 33 + stalls});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || o_valid !== 1'b0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0 || o_valid !== 1'b0) chk("drain_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        blk_t b;
        blk_t b2;
        int   n;
        fork
            monitor_loop();
        join_none

        i_rst_n    = 1'b0;
        i_valid    = 1'b1;
        i_ready    = 1'b1;
        stall_mode = 1'b0;
        key        = 32'd0;
        pt         = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};

        // Reset wins over a simultaneous i_valid.
        @(posedge clk); #1;
        chk("rst_ready", {127'd0, o_ready}, 128'd1);
        chk("rst_valid", {127'd0, o_valid}, 128'd0);
        chk("rst_busy",  {127'd0, o_busy},  128'd0);
        chk("rst_ct",    ct_v, 128'd0);
        @(posedge clk); #1;
        chk("rst_no_accept", {127'd0, o_busy}, 128'd0);
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero key / zero plaintext, with per-cycle index walk.
        send('0, 32'd0, 0, 1'b1, 1'b0);
        chk("r1_round", 128'(o_stage_round), 128'd1);
        chk("r1_idx", 128'(o_subkey_idx), 128'd0);
        chk("r1_stage_words", stage_in_v,
            {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000});
        for (int r = 2; r <= 32; r++) begin
            @(posedge clk); #1;
            chk("walk_round", 128'(o_stage_round), 128'(r));
            chk("walk_idx", 128'(o_subkey_idx), 128'(r - 1));
        end
        @(posedge clk); #1;
        chk("final_idx", 128'(o_subkey_idx), 128'd32);
        chk("final_round0", 128'(o_stage_round), 128'd0);
        chk("final_stage0", stage_in_v, 128'd0);
        chk("final_busy", {127'd0, o_busy}, 128'd1);
        wait_drain();
        chk("idle_idx", 128'(o_subkey_idx), 128'd0);

        // Back-to-back blocks with assorted keys and plaintexts.
        for (int i = 0; i < 6; i++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            send(b, $urandom, 0, 1'b1, 1'b0);
        end
        send({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
             32'hFFFF_FFFF, 0, 1'b1, 1'b0);
        wait_drain();

        // Subkey stalls: 5 cycles at round 7 plus 3 in the final mix.
        b = {32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0, 32'hFEED_FACE};
        send(b, 32'h5A5A_A5A5, 0, 1'b1, 1'b0);
        wait_drain();
        stall_mode = 1'b1;
        send(b, 32'h5A5A_A5A5, 8, 1'b1, 1'b0);
        wait_drain();
        stall_mode = 1'b0;

        // DONE back-pressure with i_valid held high; next block follows the handshake.
        b  = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        b2 = {32'h9999_AAAA, 32'hBBBB_CCCC, 32'hDDDD_EEEE, 32'hFFFF_0000};
        i_ready = 1'b0;
        send(b, 32'hC0DE_C0DE, 0, 1'b1, 1'b1);
        n = 0;
        while (o_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", {127'd0, o_valid}, 128'd1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("done_held", {127'd0, o_valid}, 128'd1);
        pt      = b2;
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("handshake_ready", {127'd0, o_ready}, 128'd1);
        chk("handshake_valid", {127'd0, o_valid}, 128'd0);
        @(posedge clk); #1;
        chk("next_accept", {127'd0, o_busy}, 128'd1);
        sb.push_back('{ct: model(b2, 32'hC0DE_C0DE), due: cyc + 33});
        i_valid = 1'b0;
        wait_drain();

        // Reset in round 20 abandons the block; the next one must be clean.
        send({32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555},
             32'h1234_5678, 0, 1'b0, 1'b0);
        n = 0;
        while (o_stage_round !== 6'd20 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_r20", 128'(o_stage_round), 128'd20);
        i_rst_n = 1'b0;
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        chk("midrst_ready", {127'd0, o_ready}, 128'd1);
        chk("midrst_busy",  {127'd0, o_busy},  128'd0);
        chk("midrst_valid", {127'd0, o_valid}, 128'd0);
        chk("midrst_ct",    ct_v, 128'd0);
        b = {32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_FFFF, 32'hFFFF_0000};
        send(b, 32'h8765_4321, 0, 1'b1, 1'b0);
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
